// File: rtl/stack_ctrl.sv
// Calculator stack command sequencer: expands one RPN command into
// paced push/pop pulses on the stack port and returns one response.
module stack_ctrl #(
  parameter int STACK_DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_num,
  output logic        st_push,
  output logic        st_pop,
  output logic [31:0] st_num,
  input  logic [9:0]  st_size,
  input  logic [31:0] st_top,
  input  logic        st_error,
  input  logic        st_vld,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_top
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, GUARD, WAIT, RESP
  } state_t;

  typedef enum logic [2:0] {
    OP_PUSH, OP_DROP, OP_ADD, OP_SUB,
    OP_MUL, OP_DUP, OP_SWAP, OP_NOP
  } op_t;

  localparam logic [9:0] FULL = 10'(STACK_DEPTH);
  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_FAULT = 2'd3;

  state_t      state;
  op_t         op_q;
  logic [31:0] num_q;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [1:0]  step;

  op_t         cop;
  logic        accept;
  logic        underflow;
  logic        overflow;
  logic [1:0]  last;

  op_t         op_s;
  logic [31:0] num_s;
  logic [31:0] y_s;
  logic [1:0]  step_s;
  logic [31:0] res;
  logic        nx_push;
  logic        nx_pop;
  logic [31:0] nx_num;

  assign cop       = op_t'(cmd_op);
  assign cmd_ready = (state == IDLE) && st_vld && !reset;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    unique case (1'b1)
      (cop == OP_DROP),
      (cop == OP_DUP):
        underflow = (st_size == 10'd0);
      (cop == OP_ADD),
      (cop == OP_SUB),
      (cop == OP_MUL),
      (cop == OP_SWAP):
        underflow = (st_size < 10'd2);
      default: ;
    endcase
    if (cop == OP_PUSH || cop == OP_DUP)
      overflow = (st_size == FULL);
  end

  always_comb begin
    last = 2'd0;
    unique case (op_q)
      OP_ADD, OP_SUB, OP_MUL: last = 2'd2;
      OP_SWAP:                last = 2'd3;
      default:                last = 2'd0;
    endcase
  end

  // At accept the latches are not loaded yet, so decode the live inputs.
  always_comb begin
    if (state == IDLE) begin
      op_s   = cop;
      num_s  = cmd_num;
      y_s    = st_top;
      step_s = 2'd0;
    end else begin
      op_s   = op_q;
      num_s  = num_q;
      y_s    = y_q;
      step_s = step + 2'd1;
    end
  end

  always_comb begin
    res = 32'd0;
    unique case (op_s)
      OP_ADD:  res = x_q + y_s;
      OP_SUB:  res = x_q - y_s;
      OP_MUL:  res = x_q * y_s;
      default: res = 32'd0;
    endcase
  end

  always_comb begin
    nx_push = 1'b0;
    nx_pop  = 1'b0;
    nx_num  = 32'd0;
    unique case (op_s)
      OP_PUSH: begin
        nx_push = 1'b1;
        nx_num  = num_s;
      end
      OP_DROP: nx_pop = 1'b1;
      OP_DUP: begin
        nx_push = 1'b1;
        nx_num  = y_s;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        nx_pop  = (step_s < 2'd2);
        nx_push = (step_s == 2'd2);
        nx_num  = (step_s == 2'd2) ? res : 32'd0;
      end
      OP_SWAP: begin
        nx_pop  = (step_s < 2'd2);
        nx_push = (step_s >= 2'd2);
        nx_num  = (step_s == 2'd2) ? y_s : x_q;
      end
      OP_NOP: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      num_q     <= 32'd0;
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      step      <= 2'd0;
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      st_num    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= E_OK;
      rsp_top   <= 32'd0;
    end else begin
      st_push   <= 1'b0;
      st_pop    <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= cop;
            num_q   <= cmd_num;
            y_q     <= st_top;
            step    <= 2'd0;
            rsp_top <= st_top;
            rsp_err <= E_OK;
            if (underflow) begin
              rsp_err   <= E_UNDER;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (overflow) begin
              rsp_err   <= E_OVER;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (cop == OP_NOP) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              st_push <= nx_push;
              st_pop  <= nx_pop;
              st_num  <= nx_num;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: state <= GUARD;
        GUARD: state <= WAIT;
        WAIT: begin
          if (st_vld) begin
            rsp_top <= st_top;
            if (st_error) begin
              rsp_err   <= E_FAULT;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (step == last) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              if (step == 2'd0)
                x_q <= st_top;
              step    <= step + 2'd1;
              st_push <= nx_push;
              st_pop  <= nx_pop;
              st_num  <= nx_num;
              state   <= ISSUE;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Command sequencer that drives the 512-entry calculator stack. It accepts one RPN command at a time over a valid/ready handshake and expands it into single-cycle push/pop pulses on the stack port. It paces those pulses against the stack's busy/valid signal and returns one response per command with the new top and an error code. It sits between the keypad/UART command parser and the stack.

## Interface
- STACK_DEPTH, 512, stack capacity used for the overflow check (compared against st_size)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  0 PUSH, 1 DROP, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 SWAP, 7 NOP
- cmd_num  in  32  operand for PUSH
- st_push  out  1  one-cycle push pulse to stack
- st_pop  out  1  one-cycle pop pulse to stack
- st_num  out  32  data for st_push
- st_size  in  10  stack occupancy
- st_top  in  32  stack top value (0 when empty)
- st_error  in  1  stack error flag
- st_vld  in  1  stack idle/ready
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  2  0 OK, 1 UNDERFLOW, 2 OVERFLOW, 3 FAULT
- rsp_top  out  32  st_top after the command completes

## Operation
- cmd_ready = (state==IDLE) && st_vld. On accept, latch op, cmd_num, and Y = st_top. Check size from st_size at the accept cycle.
- Pre-checks at accept:
  - DROP and DUP with size 0 -> UNDERFLOW.
  - ADD, SUB, MUL and SWAP with size < 2 -> UNDERFLOW.
  - PUSH and DUP with size == STACK_DEPTH -> OVERFLOW.
  - On any pre-check failure: no stack pulse; go straight to RESP.
- Stack-op primitive:
  - ISSUE: assert exactly one of st_push/st_pop for one cycle.
  - GUARD: one cycle; st_vld is ignored.
  - WAIT: hold until st_vld=1. In the WAIT cycle where st_vld=1, sample st_top and st_error.
- Micro-sequences:
  - PUSH: push cmd_num.
  - DROP: pop.
  - DUP: push Y.
  - ADD/SUB/MUL: pop; latch X = st_top; pop; push f(X,Y).
    - ADD: X+Y. SUB: X−Y. MUL: low 32 bits of X*Y.
    - All arithmetic is mod 2^32, unsigned wrap, no overflow flag.
  - SWAP: pop; latch X; pop; push Y; push X.
  - NOP: no pulses; respond with current st_top.
- States: IDLE, ISSUE, GUARD, WAIT, RESP. A step counter (0..3) selects the next primitive within the op.
- After the last WAIT, go to RESP:
  - rsp_valid=1 for one cycle.
  - rsp_top = st_top sampled in that WAIT (NOP/pre-check error: st_top sampled at accept).
  - Then return to IDLE.
- If st_error=1 is sampled in any WAIT: abort the remaining steps and respond with FAULT.
- st_push and st_pop are never high together. st_num is held stable during ISSUE.
- Reset: all outputs 0 (cmd_ready, st_push, st_pop, st_num, rsp_valid, rsp_err, rsp_top), state IDLE, latches cleared.
  - Reset mid-sequence abandons the command with no response. The stack shares reset, so no partial state survives.

## Timing
- Accept at cycle 0; first pulse at cycle 1. With a stack whose busy time is one cycle, each primitive takes 3 cycles (ISSUE, GUARD, WAIT).
- PUSH/DROP/DUP: pulse cycle 1, rsp_valid cycle 4.
- ADD/SUB/MUL: pulses cycles 1, 4, 7; rsp_valid cycle 10.
- SWAP: pulses cycles 1, 4, 7, 10; rsp_valid cycle 13.
- Pre-check error and NOP: rsp_valid cycle 1.
- A pop from size 1 leaves st_vld high throughout. The GUARD cycle makes this safe; no special case is needed.
- cmd_ready is low from the cycle after accept through the rsp_valid cycle. The earliest next accept is the cycle after rsp_valid.
- A stalled stack (st_vld low) extends WAIT indefinitely; there is no timeout.

## Test plan
- Reset, then PUSH 5, then PUSH 7 -> two responses: rsp_err 0, rsp_top 5 then 7. st_size goes to 2. Each rsp_valid arrives 4 cycles after accept.
- Stack [10, 3] (top = 3), SUB -> rsp_top 7, size 1, pulses at cycles 1/4/7, rsp at cycle 10. MUL on [0x10000, 0x10000] -> rsp_top 0 (wrap).
- Stack [1, 2], SWAP -> rsp_top 1, stack reads [2, 1] after a following DROP (rsp_top 2).
- Empty stack: DROP, ADD and DUP -> each rsp_err 1 at cycle 1, no st_pop/st_push pulses, size stays 0. Stack with one entry, ADD -> rsp_err 1, size stays 1.
- Fill to 512 entries; PUSH 9 -> rsp_err 2 with no pulse. DUP -> rsp_err 2. DROP -> rsp_err 0, size 511.
- Assert reset at cycle 5 of an ADD -> all outputs 0 the next cycle, no rsp_valid. cmd_ready returns once st_vld=1. Forced st_error=1 in a WAIT -> rsp_err 3 and the remaining steps are skipped.
